goertzel_seq_ctrl: RTL and testbench

- Frame sequencer for the Goertzel datapath.
- Per frame it clears the core accumulators, then runs N sample cycles. Each cycle: handshake one sample through the scaler (enable/valid), then strobe one Goertzel iteration.
- After N samples it triggers the final-stage computation and reports frame completion.
- Sits between the ADC front-end/host control and the scaler and Goertzel core.

---
 rtl/goertzel_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_goertzel_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_seq_ctrl.sv
// Goertzel frame sequencer: clear, N x (scaler handshake + iteration), final stage, done.
// Optional watchdog on the two wait states is built when GOERTZEL_SEQ_WDOG_EN is defined.
module goertzel_seq_ctrl #(
    parameter int N_W      = 16,
    parameter int GAP_CYC  = 3,
    parameter int TO_W     = 12,
    parameter int TO_LIMIT = 4095
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [N_W-1:0] cfg_n,
    input  logic           cfg_cont,
    input  logic           adc_rdy,
    output logic           scale_en,
    input  logic           scale_valid,
    output logic           iter_clr,
    output logic           iter_en,
    output logic           final_en,
    input  logic           final_done,
    output logic           busy,
    output logic           frame_done,
    output logic [N_W-1:0] sample_cnt,
    output logic           err_cfg,
    output logic           err_timeout
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_REQ, S_WAIT_SCALE, S_ITER,
        S_GAP, S_FINAL, S_WAIT_FINAL, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [N_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             scale_en_q, scale_en_d;
    logic             err_cfg_q, err_cfg_d;
    logic             cfg_ok;

`ifdef GOERTZEL_SEQ_WDOG_EN
    logic [TO_W-1:0]  wd_q, wd_d;
    logic             err_to_q, err_to_d;
    logic             wd_hit;
    assign wd_hit = (wd_q == TO_W'(TO_LIMIT - 1));
`endif

    assign cfg_ok = (cfg_n >= N_W'(2));

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        err_cfg_d = 1'b0;
`ifdef GOERTZEL_SEQ_WDOG_EN
        err_to_d  = err_to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        n_d     = cfg_n;
                        cnt_d   = '0;
                        state_d = S_CLEAR;
`ifdef GOERTZEL_SEQ_WDOG_EN
                        err_to_d = 1'b0;
`endif
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            S_CLEAR: state_d = S_REQ;
            S_REQ: if (adc_rdy) state_d = S_WAIT_SCALE;
            S_WAIT_SCALE: begin
                if (scale_valid) begin
                    cnt_d   = cnt_q + N_W'(1);
                    state_d = S_ITER;
                end
`ifdef GOERTZEL_SEQ_WDOG_EN
                else if (wd_hit) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end
`endif
            end
            // cnt_q already holds the count for the iteration strobed this cycle
            S_ITER: begin
                if (cnt_q == n_q) begin
                    state_d = S_FINAL;
                end else begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = S_REQ;
                else                              gap_d   = gap_q + GAP_W'(1);
            end
            S_FINAL: state_d = S_WAIT_FINAL;
            S_WAIT_FINAL: begin
                if (final_done) state_d = S_DONE;
`ifdef GOERTZEL_SEQ_WDOG_EN
                else if (wd_hit) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                if (cfg_cont && cfg_ok) begin
                    n_d     = cfg_n;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end else begin
                    err_cfg_d = cfg_cont;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            n_d       = n_q;
            cnt_d     = cnt_q;
            err_cfg_d = 1'b0;
`ifdef GOERTZEL_SEQ_WDOG_EN
            err_to_d  = err_to_q;
`endif
        end
    end

    // Scaler enable is a clean registered level that is high exactly while waiting on it
    assign scale_en_d = (state_d == S_WAIT_SCALE);

`ifdef GOERTZEL_SEQ_WDOG_EN
    always_comb begin
        wd_d = '0;
        if ((state_d == state_q) &&
            (state_q == S_WAIT_SCALE || state_q == S_WAIT_FINAL))
            wd_d = wd_q + TO_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            scale_en_q <= 1'b0;
            err_cfg_q  <= 1'b0;
`ifdef GOERTZEL_SEQ_WDOG_EN
            wd_q       <= '0;
            err_to_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            scale_en_q <= scale_en_d;
            err_cfg_q  <= err_cfg_d;
`ifdef GOERTZEL_SEQ_WDOG_EN
            wd_q       <= wd_d;
            err_to_q   <= err_to_d;
`endif
        end
    end

    assign scale_en   = scale_en_q;
    assign iter_clr   = (state_q == S_CLEAR);
    assign iter_en    = (state_q == S_ITER);
    assign final_en   = (state_q == S_FINAL);
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign sample_cnt = cnt_q;
    assign err_cfg    = err_cfg_q;

`ifdef GOERTZEL_SEQ_WDOG_EN
    assign err_timeout = err_to_q;
`else
    logic unused_wd_params;
    assign unused_wd_params = (TO_W > 0) && (TO_LIMIT > 0);
    assign err_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_goertzel_seq_ctrl.sv
// Directed bench for goertzel_seq_ctrl with a 4-cycle scaler model and 2-cycle final stage.
module tb_goertzel_seq_ctrl;

    localparam int N_W = 16;

    logic           clk = 1'b0;
    logic           rst, start, abort, cfg_cont, adc_rdy;
    logic [N_W-1:0] cfg_n;
    logic           scale_en, scale_valid, iter_clr, iter_en, final_en, final_done;
    logic           busy, frame_done, err_cfg, err_timeout;
    logic [N_W-1:0] sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    goertzel_seq_ctrl #(.N_W(N_W), .GAP_CYC(3), .TO_W(12), .TO_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_n(cfg_n),
        .cfg_cont(cfg_cont), .adc_rdy(adc_rdy), .scale_en(scale_en),
        .scale_valid(scale_valid), .iter_clr(iter_clr), .iter_en(iter_en),
        .final_en(final_en), .final_done(final_done), .busy(busy),
        .frame_done(frame_done), .sample_cnt(sample_cnt), .err_cfg(err_cfg),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // scaler model: valid pulses once scale_en has been high for 4 edges
    logic       scl_on;
    logic [2:0] sc_cnt;
    logic [1:0] fp;
    always @(posedge clk) begin
        if (rst || !scl_on || !scale_en) begin
            sc_cnt      <= 3'd0;
            scale_valid <= 1'b0;
        end else begin
            sc_cnt      <= (sc_cnt == 3'd7) ? sc_cnt : sc_cnt + 3'd1;
            scale_valid <= (sc_cnt == 3'd3);
        end
        fp <= rst ? 2'b00 : {fp[0], final_en};
    end
    assign final_done = fp[1];

    // monitors
    int cyc, n_clr, n_iter, n_fin, n_done, n_errc, n_busy, en_hi, low_run, min_low;
    int it_val[16];
    int clr_cyc[4];
    int done_cyc[4];
    bit se_prev, seen_rise;
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (iter_clr)   begin if (n_clr < 4) clr_cyc[n_clr] = cyc;   n_clr++;  end
            if (iter_en)    begin if (n_iter < 16) it_val[n_iter] = int'(sample_cnt); n_iter++; end
            if (final_en)   n_fin++;
            if (frame_done) begin if (n_done < 4) done_cyc[n_done] = cyc; n_done++; end
            if (err_cfg)    n_errc++;
            if (busy)       n_busy++;
            if (scale_en)   en_hi++;
            if (scale_en && !se_prev) begin
                if (seen_rise && low_run < min_low) min_low = low_run;
                seen_rise = 1'b1;
                low_run   = 0;
            end else if (!scale_en) begin
                low_run++;
            end
            se_prev = scale_en;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        @(negedge clk);
        #1;
        n_clr = 0; n_iter = 0; n_fin = 0; n_done = 0; n_errc = 0; n_busy = 0;
        en_hi = 0; low_run = 0; min_low = 999; seen_rise = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k;
        k = 0;
        while (!frame_done && k < lim) begin @(negedge clk); k++; end
        if (!frame_done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_cont = 1'b0; adc_rdy = 1'b0;
        cfg_n = '0; scl_on = 1'b1; cyc = 0; se_prev = 1'b0;
        idle_cycles(3);
        check("rst_busy", int'(busy), 0);
        check("rst_scale_en", int'(scale_en), 0);
        check("rst_sample_cnt", int'(sample_cnt), 0);
        check("rst_strobes", int'({iter_clr, iter_en, final_en, frame_done}), 0);
        check("rst_errs", int'({err_cfg, err_timeout}), 0);
        rst = 1'b0;

        // single frame, n=4
        clr_mon();
        cfg_n = 16'd4; adc_rdy = 1'b1;
        pulse_start();
        wait_done("f4", 300);
        idle_cycles(3);
        check("f4_iter_clr", n_clr, 1);
        check("f4_iter_en", n_iter, 4);
        for (int i = 0; i < 4; i++) check($sformatf("f4_cnt%0d", i), it_val[i], i + 1);
        check("f4_gap_low", min_low, 5);
        check("f4_final_en", n_fin, 1);
        check("f4_frame_done", n_done, 1);
        check("f4_busy_end", int'(busy), 0);
        check("f4_sample_cnt", int'(sample_cnt), 4);

        // rejected config
        clr_mon();
        cfg_n = 16'd1;
        pulse_start();
        idle_cycles(4);
        check("n1_err_cfg", n_errc, 1);
        check("n1_busy", n_busy, 0);
        check("n1_iter_clr", n_clr, 0);
        check("n1_cnt_kept", int'(sample_cnt), 4);

        // continuous mode, two frames of n=2
        clr_mon();
        cfg_n = 16'd2; cfg_cont = 1'b1;
        pulse_start();
        wait_done("c1", 300);
        @(negedge clk); cfg_cont = 1'b0;
        wait_done("c2", 300);
        idle_cycles(3);
        check("cont_frame_done", n_done, 2);
        check("cont_iter_clr", n_clr, 2);
        check("cont_clr_after_done", clr_cyc[1] - done_cyc[0], 1);
        check("cont_iter_en", n_iter, 4);
        check("cont_busy_end", int'(busy), 0);

        // abort in WAIT_SCALE after sample 2 of n=8
        clr_mon();
        cfg_n = 16'd8;
        pulse_start();
        k = 0;
        while (!(scale_en && sample_cnt == 16'd2) && k < 200) begin @(negedge clk); k++; end
        check("ab_reach", int'(scale_en && sample_cnt == 16'd2), 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("ab_busy", int'(busy), 0);
        check("ab_scale_en", int'(scale_en), 0);
        check("ab_sample_cnt", int'(sample_cnt), 2);
        idle_cycles(20);
        check("ab_final_en", n_fin, 0);
        check("ab_frame_done", n_done, 0);
        check("ab_iter_en", n_iter, 2);

        // start and abort together in IDLE
        clr_mon();
        cfg_n = 16'd4;
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        idle_cycles(3);
        check("sa_busy", n_busy, 0);
        check("sa_iter_clr", n_clr, 0);

        // scaler never answers
        clr_mon();
        scl_on = 1'b0;
        pulse_start();
`ifdef GOERTZEL_SEQ_WDOG_EN
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        check("wd_busy", int'(busy), 0);
        check("wd_err_timeout", int'(err_timeout), 1);
        check("wd_en_cycles", en_hi, 16);
        check("wd_frame_done", n_done, 0);
        check("wd_scale_en", int'(scale_en), 0);
        scl_on = 1'b1;
        pulse_start();
        check("wd_clear_on_start", int'(err_timeout), 0);
        check("wd_restart_busy", int'(busy), 1);
        wait_done("wd_rerun", 300);
        idle_cycles(2);
`else
        idle_cycles(40);
        check("nowd_busy", int'(busy), 1);
        check("nowd_err_timeout", int'(err_timeout), 0);
        check("nowd_scale_en", int'(scale_en), 1);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("nowd_abort_idle", int'(busy), 0);
        scl_on = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
